// File: rtl/jtag_ir_pkg.sv
// Shared definitions for the JTAG instruction register: TDR select bit
// indices, the select vector type, the IEEE capture pattern and the
// default opcode values.
package jtag_ir_pkg;

   // Bit positions inside the one-hot TDR select vector.
   localparam int SEL_BYPASS   = 0;
   localparam int SEL_IDCODE   = 1;
   localparam int SEL_USERCODE = 2;
   localparam int SEL_SAMPLE   = 3;
   localparam int SEL_EXTEST   = 4;
   localparam int SEL_INTEST   = 5;
   localparam int SEL_CLAMP    = 6;
   localparam int SEL_HIGHZ    = 7;
   localparam int SEL_PRIV     = 8;
   localparam int SEL_W        = 9;

   typedef logic [SEL_W-1:0] sel_t;

   // IEEE 1149.1 requires the two LSBs of the IR capture value to be 01.
   localparam logic [1:0] CAPTURE_LSB = 2'b01;

   // Default opcode values; the top casts them down to IR_WIDTH.
   localparam int DEF_OP_EXTEST   = 'h00;
   localparam int DEF_OP_IDCODE   = 'h01;
   localparam int DEF_OP_SAMPLE   = 'h02;
   localparam int DEF_OP_USERCODE = 'h03;
   localparam int DEF_OP_CLAMP    = 'h04;
   localparam int DEF_OP_HIGHZ    = 'h05;
   localparam int DEF_OP_INTEST   = 'h06;
   localparam int DEF_OP_PRIV     = 'h18;

   // One-hot select vector with only bit idx set.
   function automatic sel_t sel_onehot(input int idx);
      sel_t s;
      s = '0;
      s[idx] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/jtag_ir_decoder.sv
// Pure opcode-to-TDR-select decode. Unknown opcodes (and all-ones BYPASS)
// fall through to the bypass select; the if/else chain guarantees the
// result is exactly one-hot even if two opcode parameters collide.
module jtag_ir_decoder
   import jtag_ir_pkg::*;
#(
   parameter int                  IR_WIDTH    = 5,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(DEF_OP_EXTEST),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(DEF_OP_IDCODE),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(DEF_OP_SAMPLE),
   parameter logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(DEF_OP_USERCODE),
   parameter logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(DEF_OP_CLAMP),
   parameter logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(DEF_OP_HIGHZ),
   parameter logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(DEF_OP_INTEST),
   parameter logic [IR_WIDTH-1:0] OP_PRIV     = IR_WIDTH'(DEF_OP_PRIV)
) (
   input  logic [IR_WIDTH-1:0] op_i,
   output sel_t                sel_o,
   output logic                bsr_select_o
);

   // Priority decode of the opcode into a single select bit.
   always_comb begin
      if (op_i == '1)                sel_o = sel_onehot(SEL_BYPASS);
      else if (op_i == OP_IDCODE)    sel_o = sel_onehot(SEL_IDCODE);
      else if (op_i == OP_USERCODE)  sel_o = sel_onehot(SEL_USERCODE);
      else if (op_i == OP_SAMPLE)    sel_o = sel_onehot(SEL_SAMPLE);
      else if (op_i == OP_EXTEST)    sel_o = sel_onehot(SEL_EXTEST);
      else if (op_i == OP_INTEST)    sel_o = sel_onehot(SEL_INTEST);
      else if (op_i == OP_CLAMP)     sel_o = sel_onehot(SEL_CLAMP);
      else if (op_i == OP_HIGHZ)     sel_o = sel_onehot(SEL_HIGHZ);
      else if (op_i == OP_PRIV)      sel_o = sel_onehot(SEL_PRIV);
      else                           sel_o = sel_onehot(SEL_BYPASS);
   end

   assign bsr_select_o = sel_o[SEL_SAMPLE] | sel_o[SEL_EXTEST] | sel_o[SEL_INTEST];

endmodule

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register with shift-length checking, status capture and
// a registered one-hot TDR select.
// Optional build macro JTAG_IR_PRIV_LOCK_EN adds priv_lock/priv_viol: a
// locked commit of the private opcode is forced to BYPASS and flagged.
//
// Strobe semantics: capture_ir, shift_ir and update_ir are level qualifiers
// sampled on each rising tck edge; each high cycle is one action. When
// several are high together the priority is reset > tlr > capture > shift >
// update and the lower ones are dropped for that edge. There is no
// back-pressure: every sampled strobe is acted on.
module jtag_ir_ctrl
   import jtag_ir_pkg::*;
#(
   parameter int                  IR_WIDTH    = 5,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(DEF_OP_EXTEST),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(DEF_OP_IDCODE),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(DEF_OP_SAMPLE),
   parameter logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(DEF_OP_USERCODE),
   parameter logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(DEF_OP_CLAMP),
   parameter logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(DEF_OP_HIGHZ),
   parameter logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(DEF_OP_INTEST),
   parameter logic [IR_WIDTH-1:0] OP_PRIV     = IR_WIDTH'(DEF_OP_PRIV)
) (
   input  logic                tck,
   input  logic                reset,
   input  logic                tlr,
   input  logic                capture_ir,
   input  logic                shift_ir,
   input  logic                update_ir,
   input  logic                tdi,
   output logic                tdo,
   input  logic [IR_WIDTH-3:0] status_in,
`ifdef JTAG_IR_PRIV_LOCK_EN
   input  logic                priv_lock,
   output logic                priv_viol,
`endif
   output logic [IR_WIDTH-1:0] instruction,
   output sel_t                sel,
   output logic                bsr_select,
   output logic                instr_changed,
   output logic                len_err
);

   localparam int CW = $clog2(IR_WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(IR_WIDTH);

   logic [IR_WIDTH-1:0] shift_q, shift_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                len_err_q, len_err_d;
   logic                chg_q, chg_d;
   logic                viol_q, viol_d;
   logic [IR_WIDTH-3:0] cap_status;
   sel_t                dec_sel;
   logic                dec_bsr;

   // Decode the next instruction so sel moves on the same edge as instruction.
   jtag_ir_decoder #(
      .IR_WIDTH   (IR_WIDTH),
      .OP_EXTEST  (OP_EXTEST),
      .OP_IDCODE  (OP_IDCODE),
      .OP_SAMPLE  (OP_SAMPLE),
      .OP_USERCODE(OP_USERCODE),
      .OP_CLAMP   (OP_CLAMP),
      .OP_HIGHZ   (OP_HIGHZ),
      .OP_INTEST  (OP_INTEST),
      .OP_PRIV    (OP_PRIV)
   ) u_dec (
      .op_i        (instr_d),
      .sel_o       (dec_sel),
      .bsr_select_o(dec_bsr)
   );

   // Capture value: device status, with bit 0 replaced by the violation flag when locking is built in.
   always_comb begin
      cap_status = status_in;
`ifdef JTAG_IR_PRIV_LOCK_EN
      cap_status[0] = viol_q;
`endif
   end

   // Next-state for the shift register, count, instruction and flags (tlr > capture > shift > update).
   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      instr_d   = instr_q;
      len_err_d = len_err_q;
      chg_d     = 1'b0;
      viol_d    = viol_q;
      if (reset || tlr) begin
         shift_d   = OP_IDCODE;
         cnt_d     = '0;
         instr_d   = OP_IDCODE;
         len_err_d = 1'b0;
         viol_d    = 1'b0;
      end else if (capture_ir) begin
         shift_d = {cap_status, CAPTURE_LSB};
         cnt_d   = '0;
      end else if (shift_ir) begin
         shift_d = {tdi, shift_q[IR_WIDTH-1:1]};
         if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
      end else if (update_ir) begin
         if (cnt_q == CNT_FULL) begin
`ifdef JTAG_IR_PRIV_LOCK_EN
            if ((shift_q == OP_PRIV) && priv_lock) begin
               instr_d = '1;
               viol_d  = 1'b1;
            end else begin
               instr_d = shift_q;
               if (shift_q != OP_PRIV) viol_d = 1'b0;
            end
`else
            instr_d = shift_q;
`endif
            len_err_d = 1'b0;
            chg_d     = (instr_d != instr_q);
         end else begin
            len_err_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset; select is registered from the decoded next instruction.
   always_ff @(posedge tck) begin
      if (reset) begin
         shift_q   <= OP_IDCODE;
         cnt_q     <= '0;
         instr_q   <= OP_IDCODE;
         len_err_q <= 1'b0;
         chg_q     <= 1'b0;
         viol_q    <= 1'b0;
         sel       <= sel_onehot(SEL_IDCODE);
         bsr_select <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         instr_q   <= instr_d;
         len_err_q <= len_err_d;
         chg_q     <= chg_d;
         viol_q    <= viol_d;
         sel       <= dec_sel;
         bsr_select <= dec_bsr;
      end
   end

   assign tdo           = shift_q[0];
   assign instruction   = instr_q;
   assign instr_changed = chg_q;
   assign len_err       = len_err_q;
`ifdef JTAG_IR_PRIV_LOCK_EN
   assign priv_viol     = viol_q;
`else
   // Violation tracking has no observer without the lock feature.
   logic unused_viol;
   assign unused_viol = viol_q;
`endif

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Bench for jtag_ir_ctrl (IR_WIDTH = 5). Driver tasks apply strobes and push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_jtag_ir_ctrl;
   import jtag_ir_pkg::*;

   localparam int W = 5;

   // Expectation encoding: [19:16] = kind, [15:0] = expected value.
   localparam logic [3:0] K_INSTR = 4'd0;
   localparam logic [3:0] K_SEL   = 4'd1;
   localparam logic [3:0] K_BSR   = 4'd2;
   localparam logic [3:0] K_CHG   = 4'd3;
   localparam logic [3:0] K_LEN   = 4'd4;
   localparam logic [3:0] K_TDO   = 4'd5;
   localparam logic [3:0] K_VIOL  = 4'd6;

   logic tck = 1'b0;
   logic reset, tlr, capture_ir, shift_ir, update_ir, tdi;
   logic tdo;
   logic [W-3:0] status_in;
   logic [W-1:0] instruction;
   sel_t sel;
   logic bsr_select, instr_changed, len_err;
`ifdef JTAG_IR_PRIV_LOCK_EN
   logic priv_lock, priv_viol;
`endif

   logic [19:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   jtag_ir_ctrl #(.IR_WIDTH(W)) dut (
      .tck          (tck),
      .reset        (reset),
      .tlr          (tlr),
      .capture_ir   (capture_ir),
      .shift_ir     (shift_ir),
      .update_ir    (update_ir),
      .tdi          (tdi),
      .tdo          (tdo),
      .status_in    (status_in),
`ifdef JTAG_IR_PRIV_LOCK_EN
      .priv_lock    (priv_lock),
      .priv_viol    (priv_viol),
`endif
      .instruction  (instruction),
      .sel          (sel),
      .bsr_select   (bsr_select),
      .instr_changed(instr_changed),
      .len_err      (len_err)
   );

   // Clock and watchdog
   always #5 tck = ~tck;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic expect_val(input logic [3:0] k, input logic [15:0] v);
      exp_q.push_back({k, v});
   endtask

   task automatic step(input logic c, input logic s, input logic u, input logic d, input logic t);
      capture_ir = c; shift_ir = s; update_ir = u; tdi = d; tlr = t;
      @(posedge tck);
      #1;
      capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0; tdi = 1'b0; tlr = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] v);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < W; i++) step(0, 1, 0, v[i], 0);
      step(0, 0, 1, 0, 0);
   endtask

   task automatic idle_no_pulse();
      step(0, 0, 0, 0, 0);
      expect_val(K_CHG, 16'd0);
   endtask

   // Monitor / scoreboard
   function automatic logic [15:0] actual(input logic [3:0] k);
      case (k)
         K_INSTR: return 16'(instruction);
         K_SEL:   return 16'(sel);
         K_BSR:   return 16'(bsr_select);
         K_CHG:   return 16'(instr_changed);
         K_LEN:   return 16'(len_err);
         K_TDO:   return 16'(tdo);
`ifdef JTAG_IR_PRIV_LOCK_EN
         K_VIOL:  return 16'(priv_viol);
`endif
         default: return 16'hdead;
      endcase
   endfunction

   function automatic string kname(input logic [3:0] k);
      case (k)
         K_INSTR: return "instruction";
         K_SEL:   return "sel";
         K_BSR:   return "bsr_select";
         K_CHG:   return "instr_changed";
         K_LEN:   return "len_err";
         K_TDO:   return "tdo";
         K_VIOL:  return "priv_viol";
         default: return "unknown";
      endcase
   endfunction

   always @(negedge tck) begin
      while (exp_q.size() > 0) begin
         logic [19:0] e;
         logic [15:0] a;
         e = exp_q.pop_front();
         a = actual(e[19:16]);
         n_checks++;
         if (a === e[15:0]) n_pass++;
         else $display("FAIL %s: got %h expected %h at %0t", kname(e[19:16]), a, e[15:0], $time);
      end
   end

   // Opcode table: opcode, expected sel, expected bsr_select
   logic [W-1:0] tbl_op [5] = '{5'h00, 5'h03, 5'h04, 5'h06, 5'h09};
   logic [8:0]   tbl_sel[5] = '{9'h010, 9'h004, 9'h040, 9'h020, 9'h001};
   logic         tbl_bsr[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   // Stimulus
   initial begin
      logic [6:0] seq7;
      reset = 1'b1; tlr = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
      tdi = 1'b0; status_in = '0;
`ifdef JTAG_IR_PRIV_LOCK_EN
      priv_lock = 1'b0;
`endif
      repeat (2) @(posedge tck);
      #1;
      expect_val(K_INSTR, 16'h01);
      expect_val(K_SEL,   16'h002);
      expect_val(K_BSR,   16'd0);
      expect_val(K_CHG,   16'd0);
      expect_val(K_LEN,   16'd0);
      expect_val(K_TDO,   16'd1);
      reset = 1'b0;

      // Load BYPASS
      load(5'h1F);
      expect_val(K_INSTR, 16'h1F);
      expect_val(K_SEL,   16'h001);
      expect_val(K_CHG,   16'd1);
      idle_no_pulse();

      // Status capture shifted out LSB first: {101,01}
      status_in = 3'b101;
      step(1, 0, 0, 0, 0);
      expect_val(K_TDO, 16'd1);
      step(0, 1, 0, 0, 0); expect_val(K_TDO, 16'd0);
      step(0, 1, 0, 0, 0); expect_val(K_TDO, 16'd1);
      step(0, 1, 0, 0, 0); expect_val(K_TDO, 16'd0);
      step(0, 1, 0, 0, 0); expect_val(K_TDO, 16'd1);
      status_in = '0;

      // Back to IDCODE, then a short 3-bit shift must not commit
      step(0, 0, 0, 0, 1);
      expect_val(K_INSTR, 16'h01);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      expect_val(K_INSTR, 16'h01);
      expect_val(K_LEN,   16'd1);
      expect_val(K_CHG,   16'd0);

      // Good SAMPLE load clears len_err
      load(5'h02);
      expect_val(K_INSTR, 16'h02);
      expect_val(K_SEL,   16'h008);
      expect_val(K_BSR,   16'd1);
      expect_val(K_LEN,   16'd0);
      expect_val(K_CHG,   16'd1);

      // 7-bit over-shift: last five bits are 5'h05 (LSB first 1,0,1,0,0)
      seq7 = 7'b0010111;
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, seq7[i], 0);
      step(0, 0, 1, 0, 0);
      expect_val(K_INSTR, 16'h05);
      expect_val(K_SEL,   16'h080);
      expect_val(K_BSR,   16'd0);
      expect_val(K_CHG,   16'd1);
      load(5'h05);
      expect_val(K_INSTR, 16'h05);
      expect_val(K_CHG,   16'd0);

      // Opcode table
      for (int i = 0; i < 5; i++) begin
         load(tbl_op[i]);
         expect_val(K_INSTR, 16'(tbl_op[i]));
         expect_val(K_SEL,   16'(tbl_sel[i]));
         expect_val(K_BSR,   16'(tbl_bsr[i]));
      end

      // Unknown opcode, then re-update without capture recommits the same value
      load(5'h0A);
      expect_val(K_INSTR, 16'h0A);
      expect_val(K_SEL,   16'h001);
      step(0, 0, 1, 0, 0);
      expect_val(K_INSTR, 16'h0A);
      expect_val(K_LEN,   16'd0);
      expect_val(K_CHG,   16'd0);

      // Capture beats update on the same edge
      step(1, 0, 1, 0, 0);
      expect_val(K_INSTR, 16'h0A);
      expect_val(K_TDO,   16'd1);

      // tlr mid-shift (shift also high) wins and clears the count
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 1);
      expect_val(K_INSTR, 16'h01);
      expect_val(K_SEL,   16'h002);
      expect_val(K_TDO,   16'd1);
      step(0, 0, 1, 0, 0);
      expect_val(K_INSTR, 16'h01);
      expect_val(K_LEN,   16'd1);

`ifdef JTAG_IR_PRIV_LOCK_EN
      // Locked private opcode becomes BYPASS and flags a violation
      priv_lock = 1'b1;
      load(5'h18);
      expect_val(K_INSTR, 16'h1F);
      expect_val(K_SEL,   16'h001);
      expect_val(K_VIOL,  16'd1);
      // Violation flag appears in capture bit 2
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      expect_val(K_TDO, 16'd1);
      priv_lock = 1'b0;
      load(5'h18);
      expect_val(K_INSTR, 16'h18);
      expect_val(K_SEL,   16'h100);
      expect_val(K_VIOL,  16'd1);
      load(5'h01);
      expect_val(K_VIOL,  16'd0);
`else
      load(5'h18);
      expect_val(K_INSTR, 16'h18);
      expect_val(K_SEL,   16'h100);
`endif

      // Synchronous reset restores IDCODE
      load(5'h04);
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
      expect_val(K_INSTR, 16'h01);
      expect_val(K_SEL,   16'h002);
      expect_val(K_LEN,   16'd0);

      // Drain scoreboard
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge tck);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jtag_ir_ctrl.md
Name: jtag_ir_ctrl

Overview:
Parametrised next-generation JTAG instruction register for the TAP datapath. It adds a configurable IR width and opcode set, and extends the standard instruction set with USERCODE, CLAMP, HIGHZ, INTEST and one private debug opcode. It validates shift length, captures device status into the IR capture value, and emits a registered one-hot TDR select. It sits between the TAP controller (capture/shift/update strobes) and the TDR mux.

Parameters:
IR_WIDTH, 5, IR length in bits; legal range 3..16.
OP_EXTEST, 'h00, EXTEST opcode.
OP_IDCODE, 'h01, IDCODE opcode; also the reset and TLR value.
OP_SAMPLE, 'h02, SAMPLE/PRELOAD opcode.
OP_USERCODE, 'h03, USERCODE opcode.
OP_CLAMP, 'h04, CLAMP opcode.
OP_HIGHZ, 'h05, HIGHZ opcode.
OP_INTEST, 'h06, INTEST opcode.
OP_PRIV, 'h18, private debug opcode.
BYPASS is fixed as all-ones and is not a parameter.

Ports:
tck  in  1  TAP clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
tlr  in  1  TAP is in Test-Logic-Reset; synchronous force to IDCODE.
capture_ir  in  1  Capture-IR strobe.
shift_ir  in  1  Shift-IR strobe.
update_ir  in  1  Update-IR strobe.
tdi  in  1  serial data in.
tdo  out  1  serial data out; always shift_reg[0].
status_in  in  IR_WIDTH-2  device status, sampled at capture.
instruction  out  IR_WIDTH  active instruction.
sel  out  9  one-hot select {priv,highz,clamp,intest,extest,sample,usercode,idcode,bypass}, bit0 = bypass.
bsr_select  out  1  sample | extest | intest.
instr_changed  out  1  one-cycle pulse after a commit that changed the instruction.
len_err  out  1  sticky flag: last update was rejected for a short shift.

Behaviour:
- Reset values (reset high):
  - shift_reg = OP_IDCODE, instruction = OP_IDCODE, sel = idcode, bsr_select = 0.
  - instr_changed = 0, len_err = 0, shift count = 0.
- tlr high: same state as reset, except status_in is ignored.
- Strobe priority on the same edge: reset > tlr > capture_ir > shift_ir > update_ir. Lower-priority strobes are ignored that cycle.
- Capture:
  - shift_reg <= {status_in, 2'b01}; bits [1:0] are always 01 per IEEE 1149.1.
  - shift count <= 0.
- Shift:
  - shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]}.
  - Count increments and saturates at IR_WIDTH.
  - Shifting more than IR_WIDTH bits is legal; the last IR_WIDTH bits are retained.
- Update, count == IR_WIDTH:
  - instruction <= shift_reg; len_err <= 0.
  - instr_changed pulses on the next edge if the new value differs from the old one.
- Update, count < IR_WIDTH (includes zero shifts): instruction is unchanged and len_err <= 1. Short shifts never commit.
- Update without a preceding capture: the count keeps its current value, so the same rules apply.
- Select decode:
  - sel and bsr_select are registered from the next-instruction value, so they change on the same edge as instruction. There is no combinational path from instruction to sel.
  - Unknown opcodes decode to bypass.
  - sel is always exactly one-hot; never zero, never multi-hot.
- tdo is combinational from shift_reg[0] and is valid in every state.

Optional Feature:
JTAG_IR_PRIV_LOCK_EN
- With the macro: extra input priv_lock (1 bit).
  - An OP_PRIV commit while priv_lock = 1 sets instruction to BYPASS (all-ones) and sets sticky priv_viol.
  - priv_viol is also an output and replaces status_in[0] in the capture value.
  - priv_viol is cleared by reset, by tlr, or by a successful non-PRIV commit.
- Without the macro: priv_lock and priv_viol are absent, and OP_PRIV commits normally.

Decomposition:
- Package jtag_ir_pkg holds:
  - the sel bit-index constants (SEL_BYPASS = 0 … SEL_PRIV = 8);
  - typedef sel_t (9-bit one-hot);
  - the capture LSB constant 2'b01;
  - the default opcode constants.
- Sub-module jtag_ir_decoder: pure decode from opcode to sel_t plus bsr_select, parametrised by the opcode parameters. The registered stage lives in jtag_ir_ctrl.

Test Plan:
- Reset, then capture plus 5 shifts of 5'b11111, then update → instruction = 5'h1F, sel = 9'b000000001, instr_changed pulses once.
- Capture with status_in = 3'b101 → the next 5 tdo bits are 1,0,1,0,1 (LSB first).
- Capture plus 3 shifts, then update → instruction stays 5'h01, len_err = 1; a following good 5-bit load of 5'h02 clears len_err and sets sel[3], bsr_select = 1.
- 7-bit shift with the last 5 bits = 5'h05, then update → instruction = 5'h05, sel[7] = 1; reloading 5'h05 gives no instr_changed pulse.
- Load unknown opcode 5'h0A → sel = bypass; assert tlr mid-shift → instruction = 5'h01 and count is cleared the next cycle.
- With JTAG_IR_PRIV_LOCK_EN and priv_lock = 1, load 5'h18 → instruction = 5'h1F and priv_viol = 1; with priv_lock = 0 → instruction = 5'h18 and sel[8] = 1.
